tilt_step_tracker: RTL
======================

Name: tilt_step_tracker

Overview:
- Converts a stream of signed tilt samples from the sensor front-end into the 4-bit step index (0..11) consumed by the position display stage.
- Applies three stages before the index changes:
  - quantisation into 12 bins;
  - hysteresis around bin edges;
  - consecutive-sample qualification.
- The step index then walks one position at a time toward the qualified target, so the bubble glides instead of jumping.

Parameters:
- BIN_SHIFT, 6: log2 of bin width in sample LSBs (bin width 64).
- HYST, 8: hysteresis margin in sample LSBs applied at bin edges.
- STABLE_CNT, 4: consecutive valid samples with the same candidate required to qualify a new target (1..15).
- STEP_DIV, 1000: clocks between successive single-step moves (>=1).
- RESET_STEP, 6: step index after reset (level position).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- sample_in  input  12  signed tilt sample, two's complement
- sample_valid  input  1  one-cycle strobe, sample_in valid this cycle
- step_out  output  4  current step index 0..11, registered
- step_changed  output  1  one-cycle pulse in the cycle after step_out changes
- busy  output  1  high while step_out != target

Behaviour:
- Reset values (asynchronous, rst high):
  - step_out = RESET_STEP, target = RESET_STEP;
  - qualify counter = 0, divider = 0, candidate register = RESET_STEP;
  - step_changed = 0, busy = 0; FSM = IDLE.
- Quantisation:
  - bin(x) = clamp((x + 6*2^BIN_SHIFT) >> BIN_SHIFT, 0, 11).
  - Computed at 14-bit signed width so x +/- HYST and the offset cannot overflow.
  - Negative results clamp to 0; results above 11 clamp to 11.
- Hysteresis candidate, evaluated only on sample_valid:
  - up = bin(sample_in - HYST), dn = bin(sample_in + HYST).
  - If up > target then cand = up; else if dn < target then cand = dn; else cand = target.
- Qualification:
  - On sample_valid with cand != target: if cand equals the stored candidate, increment the counter (saturating at STABLE_CNT); otherwise store cand and set the counter to 1.
  - On sample_valid with cand == target: clear the counter.
  - When the counter reaches STABLE_CNT: target <= stored candidate, counter <= 0. This is registered, so target updates the cycle after the qualifying sample.
  - Cycles without sample_valid leave the counter unchanged.
- FSM states:
  - IDLE: step_out == target. Enter MOVE when target != step_out and clear the divider.
  - MOVE:
    - Divider counts 0..STEP_DIV-1.
    - At terminal count, step_out moves +/-1 toward target and the divider resets.
    - Return to IDLE in the same cycle step_out reaches target.
    - The first move occurs STEP_DIV clocks after entering MOVE.
- Retargeting in MOVE: qualification keeps running. A new target replaces the old one without resetting the divider, and the direction follows the new target immediately. If the new target equals the current step_out, go to IDLE and produce no move.
- Simultaneous events: a divider terminal count and a target update in the same cycle use the old target for that move.
- step_out is never outside 0..11. Moves are always exactly +/-1.
- busy = (state == MOVE), registered.
- Reset asserted mid-move aborts immediately to the reset values. There is no pending pulse after release.

Decomposition:
- Shared package (level_pkg):
  - NUM_STEPS = 12, STEP_W = 4, SAMPLE_W = 12;
  - FSM state enum {IDLE, MOVE};
  - function bin_of(signed 14-bit) returning STEP_W bits.
- One natural sub-module, step_qualifier: hysteresis, candidate register and qualify counter, outputting target plus a new_target strobe.
- The top module holds the divider, FSM and step_out.

Test Plan:
- Reset release, no samples for 50 clk -> step_out=6, busy=0, step_changed never pulses.
- STEP_DIV=4, STABLE_CNT=4, four samples of +200 (bin 9) -> target=9 after the 4th sample. step_out goes 7,8,9 at 4-clk spacing with three step_changed pulses, then busy=0.
- Samples alternating +70 and +60 (edge 64 of bin 6/7, HYST=8) for 20 samples -> step_out stays 6. Then four of +72 -> step_out becomes 7.
- Three samples of -2048 then one of 0 -> counter clears, step_out unchanged at 6. Then four of -2048 -> target=0 (clamped), step_out walks down to 0.
- While moving 6->11, qualify target 4 mid-walk at step_out=8 -> next moves are 7,6,5,4 with no overshoot beyond 8.
- rst asserted while step_out=9 in MOVE -> step_out=6, busy=0 asynchronously. After release it is idle until new qualified samples arrive.

Source files
------------

// File: rtl/level_pkg.sv
// Shared types and the sample-to-bin quantiser for the tilt step tracker.
package level_pkg;

    localparam int NUM_STEPS = 12;
    localparam int STEP_W    = 4;
    localparam int SAMPLE_W  = 12;
    localparam int CALC_W    = 14;

    typedef enum logic {
        IDLE = 1'b0,
        MOVE = 1'b1
    } state_e;

    // Offset so that sample 0 lands in the middle bin, then floor-divide and clamp.
    function automatic logic [STEP_W-1:0] bin_of(input logic signed [CALC_W-1:0] x,
                                                 input int unsigned shift);
        logic signed [CALC_W-1:0] offset;
        logic signed [CALC_W-1:0] biased;
        logic signed [CALC_W-1:0] q;
        offset = 14'sd6 <<< shift;
        biased = x + offset;
        q      = biased >>> shift;
        if (q < 14'sd0) begin
            return 4'd0;
        end else if (q > 14'sd11) begin
            return 4'd11;
        end else begin
            return q[STEP_W-1:0];
        end
    endfunction

endpackage

// File: rtl/step_qualifier.sv
// Hysteresis candidate selection and consecutive-sample qualification of the target step.
module step_qualifier
    import level_pkg::*;
#(
    parameter int BIN_SHIFT  = 6,
    parameter int HYST       = 8,
    parameter int STABLE_CNT = 4,
    parameter int RESET_STEP = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic [STEP_W-1:0]   target,
    output logic                new_target
);

    localparam logic signed [CALC_W-1:0] HYST_C     = CALC_W'(HYST);
    localparam logic [3:0]               STABLE_C   = 4'(STABLE_CNT);
    localparam logic [STEP_W-1:0]        RST_STEP_C = STEP_W'(RESET_STEP);

    logic signed [CALC_W-1:0] sample_ext;
    logic [STEP_W-1:0]        up_bin;
    logic [STEP_W-1:0]        dn_bin;
    logic [STEP_W-1:0]        cand;

    logic [STEP_W-1:0] target_q, target_d;
    logic [STEP_W-1:0] cand_q, cand_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              new_target_q, new_target_d;

    assign sample_ext = {{(CALC_W-SAMPLE_W){sample_in[SAMPLE_W-1]}}, sample_in};
    assign up_bin     = bin_of(sample_ext - HYST_C, BIN_SHIFT);
    assign dn_bin     = bin_of(sample_ext + HYST_C, BIN_SHIFT);

    // Candidate selection and qualify-counter next state.
    always_comb begin
        cand         = target_q;
        target_d     = target_q;
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        new_target_d = 1'b0;
        if (up_bin > target_q) begin
            cand = up_bin;
        end else if (dn_bin < target_q) begin
            cand = dn_bin;
        end else begin
            cand = target_q;
        end
        if (sample_valid) begin
            if (cand != target_q) begin
                if (cand == cand_q) begin
                    cnt_d = (cnt_q >= STABLE_C) ? STABLE_C : cnt_q + 4'd1;
                end else begin
                    cand_d = cand;
                    cnt_d  = 4'd1;
                end
            end else begin
                cnt_d = 4'd0;
            end
        end else begin
            cnt_d = cnt_q;
        end
        if (cnt_d == STABLE_C) begin
            target_d     = cand_d;
            cnt_d        = 4'd0;
            new_target_d = 1'b1;
        end else begin
            target_d = target_q;
        end
    end

    // Qualifier state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q     <= RST_STEP_C;
            cand_q       <= RST_STEP_C;
            cnt_q        <= 4'd0;
            new_target_q <= 1'b0;
        end else begin
            target_q     <= target_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            new_target_q <= new_target_d;
        end
    end

    assign target     = target_q;
    assign new_target = new_target_q;

endmodule

// File: rtl/tilt_step_tracker.sv
// Tilt sample to display step index: qualified target plus a rate-limited one-step walker.
module tilt_step_tracker
    import level_pkg::*;
#(
    parameter int BIN_SHIFT  = 6,
    parameter int HYST       = 8,
    parameter int STABLE_CNT = 4,
    parameter int STEP_DIV   = 1000,
    parameter int RESET_STEP = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic [STEP_W-1:0]   step_out,
    output logic                step_changed,
    output logic                busy
);

    localparam int                DIV_W      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(STEP_DIV - 1);
    localparam logic [STEP_W-1:0] RST_STEP_C = STEP_W'(RESET_STEP);

    logic [STEP_W-1:0] target;
    logic              new_target;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              changed_q, changed_d;
    logic              busy_q, busy_d;

    step_qualifier #(
        .BIN_SHIFT  (BIN_SHIFT),
        .HYST       (HYST),
        .STABLE_CNT (STABLE_CNT),
        .RESET_STEP (RESET_STEP)
    ) u_qual (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .target       (target),
        .new_target   (new_target)
    );

    // Walker next state; target is sampled as currently registered, so a
    // same-cycle retarget only affects the following move.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (target != step_q) begin
                    state_d = MOVE;
                    div_d   = {DIV_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            MOVE: begin
                if (new_target && (target == step_q)) begin
                    state_d = IDLE;
                    div_d   = {DIV_W{1'b0}};
                end else if (div_q == DIV_LAST) begin
                    div_d  = {DIV_W{1'b0}};
                    step_d = (target > step_q) ? step_q + 4'd1 : step_q - 4'd1;
                    if (step_d == target) begin
                        state_d = IDLE;
                    end else begin
                        state_d = MOVE;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = {DIV_W{1'b0}};
            end
        endcase
        changed_d = (step_d != step_q);
        busy_d    = (state_d == MOVE);
    end

    // Walker registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= {DIV_W{1'b0}};
            step_q    <= RST_STEP_C;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            step_q    <= step_d;
            changed_q <= changed_d;
            busy_q    <= busy_d;
        end
    end

    assign step_out     = step_q;
    assign step_changed = changed_q;
    assign busy         = busy_q;

endmodule
